// File: rtl/pixel_clip_fifo.sv
// Screen-clip filter and small pixel FIFO between the circle engine and the VGA write port.
// Off-screen pixels are counted and dropped; on-screen pixels queue and drain on vga_ready.
module pixel_clip_fifo #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int DEPTH    = 8,
  parameter int AW       = 3
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [8:0]  in_x,
  input  logic [7:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_plot,
  output logic        full,
  input  logic        vga_ready,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [15:0] clip_count,
  output logic        overflow
);

  localparam logic [8:0]  X_LIM    = 9'(SCREEN_W);
  localparam logic [7:0]  Y_LIM    = 8'(SCREEN_H);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic [15:0]   clip_q, clip_d;
  logic          ovf_q, ovf_d;
  pix_t          last_q, last_d;

  logic x_on, y_on, on_screen;
  logic not_empty, push, pop;
  pix_t head, wr_pix, shown;

  // A set sign bit rejects negatives before the magnitude compare.
  always_comb begin
    x_on      = !in_x[8] && (in_x < X_LIM);
    y_on      = !in_y[7] && (in_y < Y_LIM);
    on_screen = x_on && y_on;
    wr_pix    = '{x: in_x[7:0], y: in_y[6:0], c: in_colour};
  end

  always_comb begin
    not_empty = (count_q != '0);
    head      = mem_q[rptr_q];
    pop       = not_empty && vga_ready;
    push      = in_plot && on_screen && !full_q;
  end

  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d  = (count_d == FULL_CNT);
    clip_d  = clip_q;
    if (in_plot && !on_screen && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;
    ovf_d   = ovf_q | (in_plot && on_screen && full_q);
    // Remembers the head so the data outputs hold once the queue drains.
    last_d  = not_empty ? head : last_q;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      clip_q  <= '0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      clip_q  <= clip_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wptr_q] <= wr_pix;
  end

  always_comb begin
    shown      = not_empty ? head : last_q;
    vga_x      = shown.x;
    vga_y      = shown.y;
    vga_colour = shown.c;
    vga_plot   = pop;
    full       = full_q;
    clip_count = clip_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// Bench for pixel_clip_fifo: fixed vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_pixel_clip_fifo;

  logic        clk;
  logic        resetn;
  logic [8:0]  in_x;
  logic [7:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_plot;
  logic        full;
  logic        vga_ready;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [15:0] clip_count;
  logic        overflow;

  pixel_clip_fifo dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_plot    (in_plot),
    .full       (full),
    .vga_ready  (vga_ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .clip_count (clip_count),
    .overflow   (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [17:0] exp_q[$];
  logic [17:0] m_last;
  int          m_clip;
  logic        m_ovf;
  int          writes_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last = '0;
    m_clip = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; in_plot = 1'b0; in_x = '0; in_y = '0; in_colour = '0; vga_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  // One cycle: drive inputs at the falling edge, check outputs, advance the model.
  task automatic step(input logic p, input logic [8:0] x, input logic [7:0] y,
                      input logic [2:0] c, input logic r);
    int          xi, yi;
    logic        on, e_plot, m_full;
    logic [17:0] shown;
    @(negedge clk);
    in_plot = p; in_x = x; in_y = y; in_colour = c; vga_ready = r;
    #1;
    m_full = (exp_q.size() == 8);
    e_plot = (exp_q.size() != 0) && r;
    shown  = (exp_q.size() != 0) ? exp_q[0] : m_last;
    check("plot",   32'(vga_plot),   32'(e_plot));
    check("x",      32'(vga_x),      32'(shown[17:10]));
    check("y",      32'(vga_y),      32'(shown[9:3]));
    check("colour", 32'(vga_colour), 32'(shown[2:0]));
    check("full",   32'(full),       32'(m_full));
    check("clip",   32'(clip_count), 32'(m_clip));
    check("ovf",    32'(overflow),   32'(m_ovf));
    if (vga_plot) writes_seen++;
    xi = $signed(x);
    yi = $signed(y);
    on = (xi >= 0) && (xi < 160) && (yi >= 0) && (yi < 120);
    if (exp_q.size() != 0) m_last = exp_q[0];
    if (e_plot) void'(exp_q.pop_front());
    if (p && !on && m_clip < 65535) m_clip++;
    if (p && on && m_full) m_ovf = 1'b1;
    if (p && on && !m_full) exp_q.push_back({x[7:0], y[6:0], c});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        p;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  c;
    logic        r;
    logic        ep;
    logic [7:0]  ex;
    logic [6:0]  ey;
    logic [2:0]  ec;
    logic        ef;
    logic [15:0] eclip;
  } vec_t;

  vec_t vecs[14];

  initial begin
    resetn = 1'b0; in_plot = 1'b0; in_x = '0; in_y = '0; in_colour = '0; vga_ready = 1'b0;
    writes_seen = 0;
    model_reset();

    vecs[0]  = '{1'b1, 9'd80,  8'd60,  3'd1, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b1, 1'b1, 8'd80,  7'd60,  3'd1, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b1, 1'b0, 8'd80,  7'd60,  3'd1, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 9'h1FF, 8'd10,  3'd5, 1'b1, 1'b0, 8'd80,  7'd60,  3'd1, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 9'd160, 8'd10,  3'd5, 1'b1, 1'b0, 8'd80,  7'd60,  3'd1, 1'b0, 16'd1};
    vecs[5]  = '{1'b1, 9'd10,  8'd120, 3'd5, 1'b1, 1'b0, 8'd80,  7'd60,  3'd1, 1'b0, 16'd2};
    vecs[6]  = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b1, 1'b0, 8'd80,  7'd60,  3'd1, 1'b0, 16'd3};
    vecs[7]  = '{1'b1, 9'd159, 8'd119, 3'd7, 1'b0, 1'b0, 8'd80,  7'd60,  3'd1, 1'b0, 16'd3};
    vecs[8]  = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b0, 1'b0, 8'd159, 7'd119, 3'd7, 1'b0, 16'd3};
    vecs[9]  = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b1, 1'b1, 8'd159, 7'd119, 3'd7, 1'b0, 16'd3};
    vecs[10] = '{1'b1, 9'd0,   8'd0,   3'd2, 1'b1, 1'b0, 8'd159, 7'd119, 3'd7, 1'b0, 16'd3};
    vecs[11] = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b1, 1'b1, 8'd0,   7'd0,   3'd2, 1'b0, 16'd3};
    vecs[12] = '{1'b1, 9'd5,   8'hFF,  3'd4, 1'b1, 1'b0, 8'd0,   7'd0,   3'd2, 1'b0, 16'd3};
    vecs[13] = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b1, 1'b0, 8'd0,   7'd0,   3'd2, 1'b0, 16'd4};

    // Reset state and table-driven basics / clip boundaries
    do_reset();
    #1;
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_ovf",  32'(overflow), 32'd0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_plot = vecs[i].p; in_x = vecs[i].x; in_y = vecs[i].y;
      in_colour = vecs[i].c; vga_ready = vecs[i].r;
      #1;
      check("tbl_plot", 32'(vga_plot),   32'(vecs[i].ep));
      check("tbl_x",    32'(vga_x),      32'(vecs[i].ex));
      check("tbl_y",    32'(vga_y),      32'(vecs[i].ey));
      check("tbl_col",  32'(vga_colour), 32'(vecs[i].ec));
      check("tbl_full", 32'(full),       32'(vecs[i].ef));
      check("tbl_clip", 32'(clip_count), 32'(vecs[i].eclip));
    end

    // Fill to full with ready low, one extra plot overflows, then drain in order
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 9'(10 + i), 8'd20, 3'(i), 1'b0);
    step(1'b0, 9'd0, 8'd0, 3'd0, 1'b0);
    check("full_after_fill", 32'(full), 32'd1);
    check("ovf_after_9th",   32'(overflow), 32'd1);
    writes_seen = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 9'd0, 8'd0, 3'd0, 1'b1);
    check("drain_writes", 32'(writes_seen), 32'd8);
    check("drain_full",   32'(full), 32'd0);

    // Pop while full does not admit a push in that cycle
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 9'(40 + i), 8'd7, 3'd3, 1'b0);
    step(1'b1, 9'd99, 8'd9, 3'd6, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 9'd0, 8'd0, 3'd0, 1'b1);

    // Streaming through pointer wrap
    do_reset();
    writes_seen = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 9'(i), 8'd5, 3'd1, 1'b1);
    step(1'b0, 9'd0, 8'd0, 3'd0, 1'b1);
    step(1'b0, 9'd0, 8'd0, 3'd0, 1'b1);
    check("stream_writes", 32'(writes_seen), 32'd20);

    // Asynchronous reset with 5 entries buffered
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 9'(100 + i), 8'd50, 3'd2, 1'b0);
    @(negedge clk);
    in_plot = 1'b0; vga_ready = 1'b1;
    #1;
    check("pre_rst_plot", 32'(vga_plot), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_plot", 32'(vga_plot), 32'd0);
    check("mid_rst_x",    32'(vga_x),    32'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 9'd0, 8'd0, 3'd0, 1'b1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int rx, ry;
      rx = int'($urandom_range(200)) - 20;
      ry = int'($urandom_range(150)) - 15;
      step(1'($urandom_range(1)), 9'(rx), 8'(ry), 3'($urandom_range(7)),
           ($urandom_range(3) != 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 9'd0, 8'd0, 3'd0, 1'b1);

    // Clip counter saturation
    do_reset();
    for (int i = 0; i < 65534; i++) begin
      @(negedge clk);
      in_plot = 1'b1; in_x = 9'h1FF; in_y = 8'd0; vga_ready = 1'b1;
    end
    m_clip = 65534;
    for (int i = 0; i < 3; i++) step(1'b1, 9'd200, 8'd3, 3'd0, 1'b1);
    step(1'b0, 9'd0, 8'd0, 3'd0, 1'b1);
    check("clip_sat", 32'(clip_count), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
